// File: rtl/note_seq_pkg.sv
// Shared types and entry layout for the note sequencer.
// Entry format is {end, rest, pitch, dur} with the duration in the LSBs.
package note_seq_pkg;

    localparam int DUR_W     = 5;
    localparam int PITCH_LSB = DUR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_ARM,
        S_PLAY
    } state_t;

    // Sub-sequencer for the in-note prefetch of the following entry
    typedef enum logic [1:0] {
        PF_REQ,
        PF_WAIT,
        PF_DONE
    } pf_t;

    function automatic int ENTRY_W(input int pitch_w);
        return pitch_w + DUR_W + 2;
    endfunction

    function automatic int ENTRY_END(input int pitch_w);
        return pitch_w + DUR_W + 1;
    endfunction

    function automatic int ENTRY_REST(input int pitch_w);
        return pitch_w + DUR_W;
    endfunction

endpackage

// File: rtl/note_sequencer_duration_counter.sv
// Tick-driven note duration counter; a load with duration D fires
// o_done on the (D+1)th enable after the loading enable.
module duration_counter
    import note_seq_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic             i_load,
    input  logic [DUR_W-1:0] i_dur,
    output logic             o_done
);

    logic [DUR_W-1:0] count;
    logic             running;

    assign o_done = i_enable & running & ~i_load & (count == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count   <= '0;
            running <= 1'b0;
        end else if (i_load) begin
            count   <= i_dur;
            running <= 1'b1;
        end else if (i_enable && running) begin
            if (count == '0) begin
                running <= 1'b0;
            end else begin
                count <= count - DUR_W'(1);
            end
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Song ROM note sequencer: fetches entries, times each note on tempo
// ticks and prefetches the next entry while the current one plays.
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int PITCH_W = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_tick,
    input  logic                          i_start,
    input  logic                          i_stop,
    input  logic                          i_loop,
    input  logic [ADDR_W-1:0]             i_start_addr,
    output logic [ADDR_W-1:0]             o_rom_addr,
    output logic                          o_rom_rd,
    input  logic [ENTRY_W(PITCH_W)-1:0]   i_rom_data,
    output logic [PITCH_W-1:0]            o_pitch,
    output logic                          o_gate,
    output logic                          o_note_start,
    output logic                          o_busy,
    output logic                          o_finished
);

    localparam int E_END  = ENTRY_END(PITCH_W);
    localparam int E_REST = ENTRY_REST(PITCH_W);

    state_t state;
    state_t state_nx;
    pf_t    pf;

    logic [ADDR_W-1:0]  addr;
    logic               played;
    logic               pend_end;
    logic               pend_rest;
    logic [PITCH_W-1:0] pend_pitch;
    logic [DUR_W-1:0]   pend_dur;

    logic               rom_end;
    logic               rom_rest;
    logic [PITCH_W-1:0] rom_pitch;
    logic [DUR_W-1:0]   rom_dur;
    logic               rom_valid;
    logic               restart;
    logic               load;
    logic               ctr_done;

    assign rom_end   = i_rom_data[E_END];
    assign rom_rest  = i_rom_data[E_REST];
    assign rom_pitch = i_rom_data[PITCH_LSB +: PITCH_W];
    assign rom_dur   = i_rom_data[DUR_W-1:0];

    assign rom_valid = (state == S_WAIT)
                     | ((state == S_PLAY) & (pf == PF_WAIT));

    // Loop only if a note played since the last (re)start, else END is final
    assign restart = rom_valid & rom_end & i_loop & played;

    assign load = (state == S_ARM) & i_tick & ~i_stop;

    duration_counter u_dur (
        .i_clk    (i_clk),
        .i_rst    (~i_rst_n),
        .i_enable (i_tick),
        .i_load   (load),
        .i_dur    (pend_dur),
        .o_done   (ctr_done)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (i_stop) begin
            state_nx = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (i_start) state_nx = S_FETCH;
                end
                S_FETCH: begin
                    state_nx = S_WAIT;
                end
                S_WAIT: begin
                    if (restart)      state_nx = S_FETCH;
                    else if (rom_end) state_nx = S_IDLE;
                    else              state_nx = S_ARM;
                end
                S_ARM: begin
                    if (i_tick) state_nx = S_PLAY;
                end
                S_PLAY: begin
                    if (ctr_done) state_nx = pend_end ? S_IDLE : S_ARM;
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_rom_rd     = 1'b0;
        o_note_start = 1'b0;
        o_finished   = 1'b0;
        unique case (state)
            S_FETCH: o_rom_rd = 1'b1;
            S_WAIT:  o_finished = ~i_stop & rom_end & ~restart;
            S_ARM:   o_note_start = load;
            S_PLAY: begin
                o_rom_rd   = (pf == PF_REQ);
                o_finished = ~i_stop & ctr_done & pend_end;
            end
            default: ;
        endcase
    end

    assign o_busy     = (state != S_IDLE);
    assign o_rom_addr = o_rom_rd ? addr : '0;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            addr       <= '0;
            pf         <= PF_DONE;
            played     <= 1'b0;
            pend_end   <= 1'b0;
            pend_rest  <= 1'b0;
            pend_pitch <= '0;
            pend_dur   <= '0;
            o_pitch    <= '0;
            o_gate     <= 1'b0;
        end else if (i_stop) begin
            o_gate <= 1'b0;
            pf     <= PF_DONE;
        end else begin
            if ((state == S_IDLE) && i_start) begin
                addr     <= i_start_addr;
                played   <= 1'b0;
                pend_end <= 1'b0;
            end
            if (rom_valid) begin
                pend_rest  <= rom_rest;
                pend_pitch <= rom_pitch;
                pend_dur   <= rom_dur;
                if (restart) begin
                    addr   <= i_start_addr;
                    played <= 1'b0;
                end else if (rom_end) begin
                    pend_end <= 1'b1;
                end else begin
                    pend_end <= 1'b0;
                    addr     <= addr + ADDR_W'(1);
                end
            end
            if (state == S_PLAY) begin
                unique case (pf)
                    PF_REQ:  pf <= PF_WAIT;
                    PF_WAIT: pf <= restart ? PF_REQ : PF_DONE;
                    default: ;
                endcase
                if (ctr_done) o_gate <= 1'b0;
            end
            if (load) begin
                if (!pend_rest) o_pitch <= pend_pitch;
                o_gate <= ~pend_rest;
                played <= 1'b1;
                pf     <= PF_REQ;
            end
        end
    end

endmodule
